// File: rtl/tpu_p_streamer_pkg.sv
// Shared constants and FSM encoding for the tpu product-row streamer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tpu_p_streamer_pkg;

  // Product row width: four 16-bit lanes.
  localparam int WORD_WIDTH = 64;
  // P buffer address width.
  localparam int ADDR_WIDTH = 10;
  // Default streamer FIFO depth; must be a power of two and at least 2.
  localparam int STREAM_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/tpu_p_streamer_sync_fifo.sv
// tpu_sync_fifo: single-clock FIFO with registered storage and no fall-through.
// Latency: a push at cycle t is readable on dout_o/!empty_o from cycle t+1.
// Backpressure: full_o refuses a push unless a pop happens in the same cycle.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset (flushes pointers)
//   push_i, din_i    write request and data
//   pop_i            read request; ignored while empty
//   dout_o           head entry, stable until popped
//   full_o, empty_o  occupancy flags
module tpu_sync_fifo
  import tpu_p_streamer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = STREAM_FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop frees the slot this cycle, so a push on a full FIFO still lands.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign dout_o  = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/tpu_p_streamer.sv
// Captures tpu product-row writes in a FIFO and frames m rows per start as AXI-Stream.
// Latency: a row pushed at cycle t is presented on m_axis_tvalid at t+1.
// Backpressure: none upstream (tpu cannot stall); rows arriving on a full FIFO are dropped and flagged.
//
// Optional feature macro: TPU_STREAM_ADDR_EN adds m_axis_tuser (row address relative to the
// first row of the frame), carried through the FIFO alongside the row data.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, m_i             frame start pulse and row count (latched in IDLE)
//   enp_i, wep_i, addrp_i,   tpu P-buffer write strobe, enable, address, row data
//   wordp_i
//   m_axis_tdata/tvalid/     AXI-Stream master towards the DMA
//   tready/tlast[/tuser]
//   busy_o                   frame in progress (COLLECT or DRAIN)
//   done_o                   one-cycle pulse after the last beat is accepted
//   overflow_o               sticky drop flag, cleared by the next accepted start_i
module tpu_p_streamer
  import tpu_p_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = STREAM_FIFO_DEPTH,
  parameter int WORD_W     = WORD_WIDTH,
  parameter int ADDR_W     = ADDR_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] m_i,
  input  logic              enp_i,
  input  logic              wep_i,
  input  logic [ADDR_W-1:0] addrp_i,
  input  logic [WORD_W-1:0] wordp_i,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
`ifdef TPU_STREAM_ADDR_EN
  output logic [ADDR_W-1:0] m_axis_tuser,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

`ifdef TPU_STREAM_ADDR_EN
  localparam int FIFO_W = WORD_W + ADDR_W;
`else
  localparam int FIFO_W = WORD_W;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] m_q;
  logic [ADDR_W-1:0] rows_in_q;
  logic [ADDR_W-1:0] beat_cnt_q;
  logic              overflow_q;

  logic              start_ok;
  logic              push_req;
  logic              last_push;
  logic              pop;
  logic              is_last_beat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;

  assign start_ok     = start_i & (state_q == ST_IDLE);
  assign push_req     = (state_q == ST_COLLECT) & (rows_in_q != m_q) & enp_i & wep_i;
  assign last_push    = push_req & (rows_in_q == m_q - ADDR_W'(1));
  assign pop          = m_axis_tvalid & m_axis_tready;
  assign is_last_beat = (beat_cnt_q == m_q - ADDR_W'(1));

  // ---------------------------------------------------------------- FIFO
`ifdef TPU_STREAM_ADDR_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] tuser_in;

  // First row of the frame defines the base, so it always carries offset 0.
  assign tuser_in = addrp_i - ((rows_in_q == '0) ? addrp_i : base_q);
  assign fifo_din = {tuser_in, wordp_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
    end else if (push_req && rows_in_q == '0) begin
      base_q <= addrp_i;
    end
  end

  assign m_axis_tuser = fifo_dout[FIFO_W-1 -: ADDR_W];
`else
  logic unused_addrp;
  assign unused_addrp = ^addrp_i;
  assign fifo_din     = wordp_i;
`endif

  assign m_axis_tdata = fifo_dout[WORD_W-1:0];

  tpu_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (m_i == '0) ? ST_DONE : ST_COLLECT;
      end
      // Leave on the edge that takes the last row, so the final beat (and its
      // pop) can only ever be seen in DRAIN.
      ST_COLLECT: begin
        if (rows_in_q == m_q || last_push) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && is_last_beat) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // In DRAIN tvalid stays high even on an empty FIFO: after an overflow the
  // missing rows are made up with stale entries so the frame is m beats long.
  always_comb begin
    busy_o        = (state_q == ST_COLLECT) | (state_q == ST_DRAIN);
    done_o        = (state_q == ST_DONE);
    m_axis_tvalid = (state_q == ST_DRAIN) | ((state_q == ST_COLLECT) & ~fifo_empty);
    m_axis_tlast  = m_axis_tvalid & is_last_beat;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q        <= '0;
      rows_in_q  <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (start_ok) begin
      m_q        <= m_i;
      rows_in_q  <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Dropped rows still count so the frame length stays m.
      if (push_req) rows_in_q <= rows_in_q + ADDR_W'(1);
      if (pop)      beat_cnt_q <= beat_cnt_q + ADDR_W'(1);
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_tpu_p_streamer.sv
// Directed bench for tpu_p_streamer: framing, backpressure, overflow, full+pop, edge cases, reset.
// Latency: n/a (testbench).
// Backpressure: sink ready driven per test.
module tb_tpu_p_streamer;
  import tpu_p_streamer_pkg::*;

  localparam int WW = WORD_WIDTH;
  localparam int AW = ADDR_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] m_i = '0;
  logic          enp_i = 1'b0;
  logic          wep_i = 1'b0;
  logic [AW-1:0] addrp_i = '0;
  logic [WW-1:0] wordp_i = '0;
  logic [WW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
`ifdef TPU_STREAM_ADDR_EN
  logic [AW-1:0] m_axis_tuser;
`endif

  tpu_p_streamer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .m_i           (m_i),
    .enp_i         (enp_i),
    .wep_i         (wep_i),
    .addrp_i       (addrp_i),
    .wordp_i       (wordp_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
`ifdef TPU_STREAM_ADDR_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Accepted beats, sampled mid-cycle.
  logic [WW-1:0] q_dat[$];
  logic          q_last[$];
  logic [AW-1:0] q_user[$];
  int            last_beat_cyc = -1;

  always @(negedge clk_i) begin
    if (m_axis_tvalid && m_axis_tready) begin
      q_dat.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
`ifdef TPU_STREAM_ADDR_EN
      q_user.push_back(m_axis_tuser);
`endif
      if (m_axis_tlast) last_beat_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] rowdat(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'hBEEF, kk, 16'h1234 ^ kk, 16'hA000 + kk};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_q();
    q_dat.delete();
    q_last.delete();
    q_user.delete();
    last_beat_cyc = -1;
  endtask

  task automatic do_start(input int m);
    start_i = 1'b1;
    m_i     = AW'(m);
    tick();
    start_i = 1'b0;
  endtask

  task automatic drive_row(input int addr, input int k);
    enp_i   = 1'b1;
    wep_i   = 1'b1;
    addrp_i = AW'(addr);
    wordp_i = rowdat(k);
  endtask

  task automatic idle_row();
    enp_i = 1'b0;
    wep_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(done_o), 64'd1);
  endtask

  // Checks beat count, data of the first n_unique beats and tlast on the final beat only.
  task automatic chk_frame(input string tag, input int m, input int n_unique);
    int nl = 0;
    int bad = 0;
    chk({tag, "_beats"}, 64'(q_dat.size()), 64'(m));
    for (int i = 0; i < q_dat.size(); i++) begin
      if (i < n_unique && q_dat[i] !== rowdat(i)) bad++;
      if (q_last[i]) nl++;
    end
    chk({tag, "_data_bad"}, 64'(bad), 64'd0);
    chk({tag, "_nlast"}, 64'(nl), 64'd1);
    if (q_last.size() == m && m > 0) chk({tag, "_last_pos"}, 64'(q_last[m-1]), 64'd1);
  endtask

  initial begin
    logic [WW-1:0] held;

    // ---------------- reset state
    tick();
    tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // ---------------- 1: basic frame, m=10, tready=1
    clear_q();
    m_axis_tready = 1'b1;
    do_start(10);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_no_vld_yet", 64'(m_axis_tvalid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive_row(32'h200 + i, i);
      tick();
      if (i == 0) chk("t1_first_vld", 64'(m_axis_tvalid), 64'd1);
    end
    idle_row();
    wait_done("t1_done");
    chk("t1_done_lat", 64'(cyc - last_beat_cyc), 64'd1);
    tick();
    chk("t1_done_pulse", 64'(done_o), 64'd0);
    chk("t1_idle_busy", 64'(busy_o), 64'd0);
    chk_frame("t1", 10, 10);

    // ---------------- 2: backpressure, m=4
    clear_q();
    m_axis_tready = 1'b0;
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      drive_row(32'h100 + i, i);
      tick();
    end
    idle_row();
    chk("t2_vld", 64'(m_axis_tvalid), 64'd1);
    held = m_axis_tdata;
    chk("t2_head", held, rowdat(0));
    repeat (3) tick();
    chk("t2_vld_hold", 64'(m_axis_tvalid), 64'd1);
    chk("t2_dat_hold", m_axis_tdata, rowdat(0));
    chk("t2_tlast_hold", 64'(m_axis_tlast), 64'd0);
    m_axis_tready = 1'b1;
    wait_done("t2_done");
    chk("t2_ovf", 64'(overflow_o), 64'd0);
    chk_frame("t2", 4, 4);
    tick();

    // ---------------- 3: overflow, m=20 with depth 16
    clear_q();
    m_axis_tready = 1'b0;
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      drive_row(32'h000 + i, i);
      tick();
    end
    idle_row();
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    m_axis_tready = 1'b1;
    wait_done("t3_done");
    chk("t3_ovf_sticky", 64'(overflow_o), 64'd1);
    chk_frame("t3", 20, 16);
    tick();
    clear_q();
    do_start(1);
    chk("t3_ovf_clr", 64'(overflow_o), 64'd0);
    drive_row(32'h050, 0);
    tick();
    idle_row();
    wait_done("t3b_done");
    chk_frame("t3b", 1, 1);
    tick();

    // ---------------- 4: full FIFO + simultaneous push/pop
    clear_q();
    m_axis_tready = 1'b0;
    do_start(17);
    for (int i = 0; i < 16; i++) begin
      drive_row(32'h080 + i, i);
      tick();
    end
    chk("t4_ovf_full", 64'(overflow_o), 64'd0);
    drive_row(32'h090, 16);
    m_axis_tready = 1'b1;
    tick();
    idle_row();
    chk("t4_ovf_after", 64'(overflow_o), 64'd0);
    wait_done("t4_done");
    chk_frame("t4", 17, 17);
    tick();

    // ---------------- 5: m=0 and stray writes in IDLE
    clear_q();
    do_start(0);
    chk("t5_done_m0", 64'(done_o), 64'd1);
    chk("t5_vld_m0", 64'(m_axis_tvalid), 64'd0);
    tick();
    chk("t5_done_off", 64'(done_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive_row(32'h010 + i, i);
      tick();
      chk("t5_stray_vld", 64'(m_axis_tvalid), 64'd0);
    end
    idle_row();
    repeat (2) tick();
    chk("t5_stray_beats", 64'(q_dat.size()), 64'd0);

    // ---------------- 6: reset mid-frame
    clear_q();
    m_axis_tready = 1'b0;
    do_start(8);
    for (int i = 0; i < 3; i++) begin
      drive_row(32'h040 + i, 100 + i);
      tick();
    end
    idle_row();
    chk("t6_vld_pre", 64'(m_axis_tvalid), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_vld_rst", 64'(m_axis_tvalid), 64'd0);
    chk("t6_busy_rst", 64'(busy_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    clear_q();
    m_axis_tready = 1'b1;
    do_start(2);
    for (int i = 0; i < 2; i++) begin
      drive_row(32'h300 + i, i);
      tick();
    end
    idle_row();
    wait_done("t6_done");
    chk_frame("t6", 2, 2);
`ifdef TPU_STREAM_ADDR_EN
    if (q_user.size() == 2) begin
      chk("t6_tuser0", 64'(q_user[0]), 64'd0);
      chk("t6_tuser1", 64'(q_user[1]), 64'd1);
    end
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
